// File: rtl/sopc_timer_host.sv
// Avalon-MM master that programs a 16-bit interval timer, services its IRQ and emits one tick per timeout.
// Optional counter snapshot readback after each tick is enabled by defining SOPC_TIMER_HOST_SNAP_EN.
module sopc_timer_host #(
    parameter int MIN_PERIOD = 16,
    parameter int TICK_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_continuous,
    output logic                  busy,
    output logic                  running,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic                  snap_valid,
    output logic [31:0]           snap_value,
    output logic [2:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [15:0]           avm_writedata,
    input  logic [15:0]           avm_readdata,
    input  logic                  tim_irq
);

    typedef enum logic [3:0] {
        IDLE, W_STOP, W_PERL, W_PERH, W_CLR, W_CTRL, RUN, ACK, HALT,
        SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE
    } state_t;

    state_t                state_reg, state_next, resume_state;
    logic [31:0]           period_reg;
    logic                  cont_reg;
    logic                  stop_pend_reg;
    logic [TICK_CNT_W-1:0] tick_count_reg;
    logic                  tick_reg;
    logic                  cs_reg, cs_next;
    logic                  wn_reg, wn_next;
    logic [2:0]            addr_reg, addr_next;
    logic [15:0]           wd_reg, wd_next;
    logic                  stop_now;

    assign stop_now = stop_pend_reg | cfg_stop;

    // A one-shot timer stops itself, so no HALT write is needed after its single timeout.
    assign resume_state = !cont_reg ? IDLE : (stop_now ? HALT : RUN);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg_start && !cfg_stop) state_next = W_STOP;
            W_STOP:  state_next = W_PERL;
            W_PERL:  state_next = W_PERH;
            W_PERH:  state_next = W_CLR;
            W_CLR:   state_next = W_CTRL;
            W_CTRL:  state_next = stop_now ? HALT : RUN;
            RUN: begin
                if (tim_irq)       state_next = ACK;
                else if (cfg_stop) state_next = HALT;
            end
`ifdef SOPC_TIMER_HOST_SNAP_EN
            ACK:       state_next = SNAP_W;
            SNAP_W:    state_next = SNAP_RL;
            SNAP_RL:   state_next = SNAP_RH;
            SNAP_RH:   state_next = SNAP_DONE;
            SNAP_DONE: state_next = resume_state;
`else
            ACK:       state_next = resume_state;
`endif
            HALT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset) state_next = IDLE;
    end

    // Bus strobes are registered from the next state, so reset always leaves the bus quiet.
    always_comb begin
        cs_next   = 1'b0;
        wn_next   = 1'b1;
        addr_next = 3'd0;
        wd_next   = 16'h0000;
        case (state_next)
            W_STOP: begin cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd1; wd_next = 16'h0008; end
            W_PERL: begin cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd2; wd_next = period_reg[15:0]; end
            W_PERH: begin cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd3; wd_next = period_reg[31:16]; end
            W_CLR:  begin cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd0; end
            W_CTRL: begin
                cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd1;
                wd_next = {12'h000, 1'b0, 1'b1, cont_reg, 1'b1};
            end
            ACK:    begin cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd0; end
            HALT:   begin cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd1; wd_next = 16'h0008; end
`ifdef SOPC_TIMER_HOST_SNAP_EN
            SNAP_W:  begin cs_next = 1'b1; wn_next = 1'b0; addr_next = 3'd4; end
            SNAP_RL: begin cs_next = 1'b1; addr_next = 3'd4; end
            SNAP_RH: begin cs_next = 1'b1; addr_next = 3'd5; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            period_reg     <= 32'h0;
            cont_reg       <= 1'b0;
            stop_pend_reg  <= 1'b0;
            tick_count_reg <= '0;
            tick_reg       <= 1'b0;
            cs_reg         <= 1'b0;
            wn_reg         <= 1'b1;
            addr_reg       <= 3'd0;
            wd_reg         <= 16'h0000;
        end else begin
            state_reg <= state_next;
            tick_reg  <= (state_next == ACK);
            cs_reg    <= cs_next;
            wn_reg    <= wn_next;
            addr_reg  <= addr_next;
            wd_reg    <= wd_next;
            if (state_reg == IDLE && state_next == W_STOP) begin
                period_reg     <= (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;
                cont_reg       <= cfg_continuous;
                tick_count_reg <= '0;
            end else if (state_next == ACK) begin
                tick_count_reg <= tick_count_reg + TICK_CNT_W'(1);
            end
            if (state_next == IDLE)
                stop_pend_reg <= 1'b0;
            else if (cfg_stop && state_reg != IDLE)
                stop_pend_reg <= 1'b1;
        end
    end

`ifdef SOPC_TIMER_HOST_SNAP_EN
    logic [15:0] snap_lo_reg;
    logic [31:0] snap_value_reg;
    logic        snap_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_lo_reg    <= 16'h0000;
            snap_value_reg <= 32'h0;
            snap_valid_reg <= 1'b0;
        end else begin
            snap_valid_reg <= 1'b0;
            if (state_reg == SNAP_RH)
                snap_lo_reg <= avm_readdata;
            if (state_reg == SNAP_DONE) begin
                snap_value_reg <= {avm_readdata, snap_lo_reg};
                snap_valid_reg <= 1'b1;
            end
        end
    end

    assign snap_value = snap_value_reg;
    assign snap_valid = snap_valid_reg;
`else
    logic unused_readdata;
    assign unused_readdata = &{1'b0, avm_readdata};
    assign snap_value      = 32'h0;
    assign snap_valid      = 1'b0;
`endif

    assign busy           = (state_reg != IDLE) && (state_reg != RUN);
    assign running        = (state_reg == RUN);
    assign tick           = tick_reg;
    assign tick_count     = tick_count_reg;
    assign avm_chipselect = cs_reg;
    assign avm_write_n    = wn_reg;
    assign avm_address    = addr_reg;
    assign avm_writedata  = wd_reg;

endmodule

// File: tb/tb_sopc_timer_host.sv
// Directed bench for sopc_timer_host: bus trace, IRQ service, clamping, stop/reset handling, optional snapshot.
module tb_sopc_timer_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [31:0] cfg_period = 32'h0;
    logic        cfg_continuous = 1'b0;
    logic        busy, running, tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'h0000;
    logic        tim_irq = 1'b0;

    int checks = 0;
    int failures = 0;

    sopc_timer_host #(.MIN_PERIOD(16), .TICK_CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
        .snap_valid(snap_valid), .snap_value(snap_value),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .tim_irq(tim_irq)
    );

    always #5 clk = ~clk;

    // Registered slave read port: snapshot 0x0001_2345 at addresses 4/5.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd4) ? 16'h2345 :
                            (avm_address == 3'd5) ? 16'h0001 : 16'h0000;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic bus_wr(input string tag, input logic [2:0] addr, input logic [15:0] data);
        check(tag, {11'h0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
              {11'h0, 1'b1, 1'b0, addr, data});
    endtask

    task automatic bus_rd(input string tag, input logic [2:0] addr);
        check(tag, {11'h0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
              {11'h0, 1'b1, 1'b1, addr, 16'h0000});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Waits (bounded) until the FSM is in RUN (want_run=1) or IDLE (want_run=0).
    task automatic wait_state(input string tag, input logic want_run);
        int n = 0;
        while (!(want_run ? running : (!running && !busy)) && n < 12) begin
            step();
            n++;
        end
        check(tag, {31'h0, (want_run ? running : (!running && !busy))}, 32'h1);
    endtask

    task automatic start(input logic [31:0] p, input logic c);
        cfg_start = 1'b1; cfg_period = p; cfg_continuous = c;
        step();
        cfg_start = 1'b0;
    endtask

    initial begin
        step(); step(); step();
        reset = 1'b0;
        check("rst_outputs", {busy, running, tick, snap_valid, avm_chipselect, avm_address},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        check("rst_write_n", {31'h0, avm_write_n}, 32'h1);
        check("rst_tick_count", {16'h0, tick_count}, 32'h0);
        check("rst_wdata", {16'h0, avm_writedata}, 32'h0);
        check("rst_snap_value", snap_value, 32'h0);
        step();

        // 1: program P=1000 continuous
        start(32'd1000, 1'b1);
        bus_wr("t1_stop", 3'd1, 16'h0008);
        check("t1_busy", {31'h0, busy}, 32'h1);
        step(); bus_wr("t1_perl", 3'd2, 16'h03E8);
        step(); bus_wr("t1_perh", 3'd3, 16'h0000);
        step(); bus_wr("t1_clr", 3'd0, 16'h0000);
        step(); bus_wr("t1_ctrl", 3'd1, 16'h0007);
        step();
        check("t1_running", {30'h0, running, busy}, 32'h2);
        check("t1_idle_bus", {31'h0, avm_chipselect}, 32'h0);

        // 2: three serviced timeouts
        for (int i = 0; i < 3; i++) begin
            step(); step();
            check("t2_no_tick", {31'h0, tick}, 32'h0);
            tim_irq = 1'b1;
            step();
            check("t2_tick", {31'h0, tick}, 32'h1);
            bus_wr("t2_ack", 3'd0, 16'h0000);
            check("t2_count", {16'h0, tick_count}, 32'(i + 1));
            tim_irq = 1'b0;
            step();
            check("t2_tick_drop", {31'h0, tick}, 32'h0);
            wait_state("t2_back_run", 1'b1);
        end
        check("t2_total", {16'h0, tick_count}, 32'd3);
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        bus_wr("t2_halt", 3'd1, 16'h0008);
        step();
        check("t2_idle", {30'h0, busy, running}, 32'h0);

        // 3: clamped one-shot
        start(32'd5, 1'b0);
        bus_wr("t3_stop", 3'd1, 16'h0008);
        step(); bus_wr("t3_perl", 3'd2, 16'h0010);
        step(); bus_wr("t3_perh", 3'd3, 16'h0000);
        step(); bus_wr("t3_clr", 3'd0, 16'h0000);
        step(); bus_wr("t3_ctrl", 3'd1, 16'h0005);
        step();
        check("t3_running", {31'h0, running}, 32'h1);
        check("t3_count_cleared", {16'h0, tick_count}, 32'h0);
        tim_irq = 1'b1;
        step();
        check("t3_tick", {31'h0, tick}, 32'h1);
        bus_wr("t3_ack", 3'd0, 16'h0000);
        tim_irq = 1'b0;
        step();
        wait_state("t3_idle", 1'b0);
        check("t3_count", {16'h0, tick_count}, 32'h1);

        // 4: stop during W_PERH, IRQ held high afterwards
        start(32'd1000, 1'b1);
        step();
        step();
        bus_wr("t4_perh", 3'd3, 16'h0000);
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        tim_irq = 1'b1;
        bus_wr("t4_clr", 3'd0, 16'h0000);
        step(); bus_wr("t4_ctrl", 3'd1, 16'h0007);
        step(); bus_wr("t4_halt", 3'd1, 16'h0008);
        check("t4_halt_tick", {30'h0, tick, running}, 32'h0);
        step();
        check("t4_idle", {29'h0, busy, running, tick}, 32'h0);
        step();
        check("t4_no_tick", {30'h0, tick, avm_chipselect}, 32'h0);
        tim_irq = 1'b0;

        // 5: start+stop together ignored, then reset during W_CLR
        cfg_start = 1'b1; cfg_stop = 1'b1; cfg_period = 32'd1000; cfg_continuous = 1'b1;
        step();
        cfg_start = 1'b0; cfg_stop = 1'b0;
        check("t5_ignored", {30'h0, avm_chipselect, busy}, 32'h0);
        step();
        check("t5_still_idle", {30'h0, avm_chipselect, busy}, 32'h0);
        start(32'd1000, 1'b1);
        step(); step(); step();
        bus_wr("t5_clr", 3'd0, 16'h0000);
        reset = 1'b1;
        step();
        check("t5_rst_state", {28'h0, busy, running, tick, avm_chipselect}, 32'h0);
        check("t5_rst_bus", {12'h0, avm_write_n, avm_address, avm_writedata}, {12'h0, 1'b1, 3'd0, 16'h0});
        reset = 1'b0;
        step();
        check("t5_quiet", {30'h0, avm_chipselect, busy}, 32'h0);

`ifdef SOPC_TIMER_HOST_SNAP_EN
        // 6: snapshot readback
        start(32'd1000, 1'b1);
        wait_state("t6_run", 1'b1);
        tim_irq = 1'b1;
        step();
        check("t6_tick", {31'h0, tick}, 32'h1);
        tim_irq = 1'b0;
        step(); bus_wr("t6_snap_w", 3'd4, 16'h0000);
        step(); bus_rd("t6_read_lo", 3'd4);
        step(); bus_rd("t6_read_hi", 3'd5);
        step();
        check("t6_done_quiet", {30'h0, avm_chipselect, snap_valid}, 32'h0);
        step();
        check("t6_valid", {30'h0, snap_valid, running}, 32'h3);
        check("t6_value", snap_value, 32'h0001_2345);
        step();
        check("t6_valid_drop", {31'h0, snap_valid}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
